uart_tx_engine: RTL and testbench

//  Parametrised UART transmitter: buffers bytes from the register file in an internal FIFO and serialises

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_tx_engine.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths: FSM states, parity codes and data-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_GUARD
  } tx_state_t;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_ODD  = 2'b01;
  localparam logic [1:0] P_EVEN = 2'b10;

  // Data field width for a ds code, clipped to the widest field the datapath carries.
  function automatic logic [3:0] data_bits(input logic [1:0] ds, input int max_w);
    logic [3:0] n;
    n = 4'(ds) + 4'd5;
    if (int'(n) > max_w) n = 4'(max_w);
    return n;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with push/pop and full/empty flags; pushes when full and pops when empty are ignored.
// No same-edge bypass: a pop frees a slot for pushing only from the following cycle.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO-buffered bytes serialised as 5-8 data bits, optional parity, 1-2 stop bits,
// plus break generation; the serial line is a flop that resets (asynchronously) to idle-high.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W = 8,
  parameter int CLK_DIV_W  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CLK_DIV_W-1:0]  cr_clk_div_i,
  input  logic [1:0]            cr_ds_i,
  input  logic [1:0]            cr_p_i,
  input  logic                  cr_s_i,
  input  logic                  cr_brk_i,
  input  logic                  tx_valid_i,
  input  logic [MAX_DATA_W-1:0] tx_data_i,
  output logic                  tx_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  uart_tx_o
);

  tx_state_t             state, state_n;
  logic [CLK_DIV_W-1:0]  baud_cnt, baud_n;
  logic [CLK_DIV_W-1:0]  div_m1, div_m1_n, cr_div_m1;
  logic [3:0]            bit_cnt, bit_n;
  logic [3:0]            nbits, nbits_n;
  logic [3:0]            frame_bits;
  logic [1:0]            par_mode, par_mode_n;
  logic                  two_stop, two_stop_n;
  logic [MAX_DATA_W-1:0] shift, shift_n;
  logic                  par, par_n;
  logic                  line_n, done_n;
  logic                  bit_end, brk_elapsed;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [MAX_DATA_W-1:0] fifo_data;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MAX_DATA_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (tx_valid_i),
    .push_data (tx_data_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_ready_o = !fifo_full;
  assign cr_div_m1  = (cr_clk_div_i == '0) ? '0 : cr_clk_div_i - 1'b1;
  assign bit_end    = (baud_cnt == '0);

  // Break must last at least one frame of the latched format; bit_cnt counts elapsed bit periods.
  assign frame_bits  = 4'd2 + nbits + {3'b000, par_mode != P_NONE} + {3'b000, two_stop};
  assign brk_elapsed = (bit_cnt == frame_bits) || (bit_end && (bit_cnt == frame_bits - 4'd1));

  always_comb begin
    state_n    = state;
    div_m1_n   = div_m1;
    nbits_n    = nbits;
    par_mode_n = par_mode;
    two_stop_n = two_stop;
    shift_n    = shift;
    par_n      = par;
    bit_n      = bit_cnt;
    done_n     = 1'b0;
    fifo_pop   = 1'b0;
    line_n     = 1'b1;
    baud_n     = bit_end ? div_m1 : baud_cnt - 1'b1;

    case (state)
      ST_IDLE: begin
        baud_n = cr_div_m1;
        bit_n  = '0;
        if (cr_brk_i || !fifo_empty) begin
          div_m1_n   = cr_div_m1;
          nbits_n    = data_bits(cr_ds_i, MAX_DATA_W);
          par_mode_n = cr_p_i;
          two_stop_n = cr_s_i;
          if (cr_brk_i) begin
            state_n = ST_BREAK;
          end else begin
            fifo_pop = 1'b1;
            shift_n  = fifo_data;
            par_n    = 1'b0;
            state_n  = ST_START;
          end
        end
      end
      ST_START: begin
        if (bit_end) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          par_n   = par ^ shift[0];
          shift_n = shift >> 1;
          if (bit_cnt == nbits - 4'd1) begin
            bit_n   = '0;
            state_n = (par_mode != P_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (two_stop && (bit_cnt == '0)) begin
            bit_n = 4'd1;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (bit_end && (bit_cnt != frame_bits)) bit_n = bit_cnt + 4'd1;
        if (!cr_brk_i && brk_elapsed) begin
          state_n = ST_GUARD;
          baud_n  = div_m1;
          bit_n   = '0;
        end
      end
      ST_GUARD: begin
        if (bit_end) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // The line flop carries the level of the state being entered.
    case (state_n)
      ST_START, ST_BREAK: line_n = 1'b0;
      ST_DATA:            line_n = shift_n[0];
      ST_PARITY:          line_n = par_n ^ (par_mode_n == P_ODD);
      default:            line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      div_m1    <= '0;
      nbits     <= 4'd5;
      par_mode  <= P_NONE;
      two_stop  <= 1'b0;
      shift     <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
      uart_tx_o <= 1'b1;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      div_m1    <= div_m1_n;
      nbits     <= nbits_n;
      par_mode  <= par_mode_n;
      two_stop  <= two_stop_n;
      shift     <= shift_n;
      par       <= par_n;
      bit_cnt   <= bit_n;
      uart_tx_o <= line_n;
      done_o    <= done_n;
      busy_o    <= (state != ST_IDLE) || !fifo_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: directed frames, FIFO fill, break, reset and randomised bursts
// checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_engine;

  localparam int MAX_DATA_W = 8;
  localparam int CLK_DIV_W  = 16;
  localparam int FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [CLK_DIV_W-1:0]  cr_clk_div = '0;
  logic [1:0]            cr_ds = '0;
  logic [1:0]            cr_p = '0;
  logic                  cr_s = 1'b0;
  logic                  cr_brk = 1'b0;
  logic                  tx_valid = 1'b0;
  logic [MAX_DATA_W-1:0] tx_data = '0;
  logic                  tx_ready, busy, done, uart_tx;

  int total = 0;
  int bad   = 0;
  int g_div, g_ds, g_p, g_s;

  uart_tx_engine #(
    .MAX_DATA_W (MAX_DATA_W),
    .CLK_DIV_W  (CLK_DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cr_clk_div_i (cr_clk_div),
    .cr_ds_i      (cr_ds),
    .cr_p_i       (cr_p),
    .cr_s_i       (cr_s),
    .cr_brk_i     (cr_brk),
    .tx_valid_i   (tx_valid),
    .tx_data_i    (tx_data),
    .tx_ready_o   (tx_ready),
    .busy_o       (busy),
    .done_o       (done),
    .uart_tx_o    (uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a list of line levels, one per bit period.
  function automatic int frame_len(input int ds, input int p, input int s);
    return 1 + (5 + ds) + ((p != 0) ? 1 : 0) + 1 + s;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int ds, input int p, input int s, input int k);
    int n, ones;
    logic [7:0] m;
    n = 5 + ds;
    if (k == 0) return 1'b0;
    if (k <= n) return d[k-1];
    if ((p != 0) && (k == n + 1)) begin
      m    = d & 8'((1 << n) - 1);
      ones = $countones(m);
      return (p == 1) ? ~ones[0] : ones[0];
    end
    return 1'b1;
  endfunction

  task automatic set_cfg(input int div, input int ds, input int p, input int s);
    g_div = div; g_ds = ds; g_p = p; g_s = s;
    cr_clk_div = 16'(div);
    cr_ds      = 2'(ds);
    cr_p       = 2'(p);
    cr_s       = 1'(s);
  endtask

  // Entered #1 after the edge preceding the start bit; returns #1 after the idle cycle that ends the frame.
  task automatic expect_frame(input logic [7:0] d, input string tag);
    int n, de, done_seen;
    n = frame_len(g_ds, g_p, g_s);
    de = (g_div == 0) ? 1 : g_div;
    done_seen = 0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < de; c++) begin
        @(posedge clk); #1;
        chk($sformatf("%s.b%0d.c%0d", tag, k, c), uart_tx, frame_bit(d, g_ds, g_p, g_s, k));
        if (done === 1'b1) done_seen++;
        if (k == 1 && c == 0) chk({tag, ".busy"}, busy, 1);
      end
    end
    chk({tag, ".early_done"}, done_seen, 0);
    @(posedge clk); #1;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".idle"}, uart_tx, 1);
  endtask

  task automatic send1(input logic [7:0] d, input string tag, input bit scramble);
    fork
      begin
        chk({tag, ".rdy"}, tx_ready, 1);
        tx_valid = 1'b1; tx_data = d;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        if (scramble) begin
          repeat (5) @(posedge clk);
          #1;
          cr_clk_div = 16'($urandom_range(1, 9));
          cr_ds = 2'($urandom);
          cr_p  = 2'($urandom);
          cr_s  = 1'($urandom);
        end
      end
      begin
        @(posedge clk); #1;
        expect_frame(d, tag);
      end
    join
    @(posedge clk); #1;
    chk({tag, ".busy_off"}, busy, 0);
  endtask

  // Pushes one byte per cycle from an idle engine; acceptance predicted from FIFO occupancy.
  task automatic send_burst(input logic [7:0] bytes[$], input string tag);
    logic [7:0] acc[$];
    bit rdy_exp[$];
    int occ;
    bit popped, pop_now;
    occ = 0; popped = 0;
    foreach (bytes[i]) begin
      rdy_exp.push_back(occ < FIFO_DEPTH);
      pop_now = !popped && (occ > 0);
      if (occ < FIFO_DEPTH) begin
        acc.push_back(bytes[i]);
        occ++;
      end
      if (pop_now) begin
        occ--;
        popped = 1;
      end
    end
    fork
      begin
        foreach (bytes[i]) begin
          chk($sformatf("%s.rdy%0d", tag, i), tx_ready, rdy_exp[i]);
          tx_valid = 1'b1; tx_data = bytes[i];
          @(posedge clk); #1;
        end
        tx_valid = 1'b0;
      end
      begin
        @(posedge clk); #1;
        foreach (acc[j]) expect_frame(acc[j], $sformatf("%s.f%0d", tag, j));
      end
    join
    @(posedge clk); #1;
    chk({tag, ".busy_off"}, busy, 0);
  endtask

  initial begin
    logic [7:0] bq[$];
    int fl, low, done_seen, nb;

    #12;
    chk("rst.line", uart_tx, 1);
    chk("rst.ready", tx_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    set_cfg(4, 3, 0, 0); send1(8'hA5, "t1", 1);
    set_cfg(3, 2, 1, 1); send1(8'h41, "t2", 0);
    set_cfg(2, 0, 2, 0); send1(8'h1F, "t3", 0);
    set_cfg(0, 0, 3, 1); send1(8'hE6, "d0", 0);

    set_cfg(2, 3, 0, 0);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_burst(bq, "t4");

    for (int it = 0; it < 6; it++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      bq = {};
      nb = $urandom_range(1, 4);
      repeat (nb) bq.push_back(8'($urandom));
      send_burst(bq, $sformatf("rnd%0d", it));
    end

    // Break requested mid-frame: frame finishes, then break, guard, then the queued byte.
    set_cfg(2, 3, 0, 0);
    fl = frame_len(3, 0, 0) * 2;
    fork
      begin
        tx_valid = 1'b1; tx_data = 8'h3C;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cr_brk = 1'b1;
        tx_valid = 1'b1; tx_data = 8'hC3;
        @(posedge clk); #1;
        tx_valid = 1'b0;
      end
      begin
        @(posedge clk); #1;
        expect_frame(8'h3C, "t5a");
      end
    join
    done_seen = 0;
    for (int i = 0; i < 3 * fl; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5.brk%0d", i), uart_tx, 0);
      if (done === 1'b1) done_seen++;
    end
    chk("t5.brk_busy", busy, 1);
    chk("t5.brk_done", done_seen, 0);
    cr_brk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5.guard%0d", i), uart_tx, 1);
    end
    expect_frame(8'hC3, "t5b");

    // Short break request still holds the line low for one full frame time.
    @(posedge clk); #1;
    cr_brk = 1'b1;
    low = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (i == 1) cr_brk = 1'b0;
      if (uart_tx === 1'b0) low++;
      else break;
    end
    chk("t5.short_brk_min", low >= fl, 1);
    chk("t5.short_brk_max", low <= fl + 1, 1);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of the data field.
    set_cfg(3, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 8'h00;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6.pre_line", uart_tx, 0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("t6.line", uart_tx, 1);
    chk("t6.ready", tx_ready, 1);
    chk("t6.busy", busy, 0);
    chk("t6.done", done, 0);
    @(negedge clk); rst = 1'b0;
    low = 0; done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) low++;
      if (done !== 1'b0) done_seen++;
    end
    chk("t6.quiet_line", low, 0);
    chk("t6.no_done", done_seen, 0);
    chk("t6.busy_after", busy, 0);
    send1(8'h5A, "t6n", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
